// File: rtl/containment_pkg.sv
// Shared constants for the containment monitor: phase encodings, default dwell ticks, LFSR seed/taps.
// Pure declarations, no logic.
package containment_pkg;

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_GREEN  = 3'd1;
    localparam logic [2:0] PH_YELLOW = 3'd2;
    localparam logic [2:0] PH_RED    = 3'd3;
    localparam logic [2:0] PH_LOCK   = 3'd4;
    localparam logic [2:0] PH_BREACH = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = PH_IDLE,
        S_GREEN  = PH_GREEN,
        S_YELLOW = PH_YELLOW,
        S_RED    = PH_RED,
        S_LOCK   = PH_LOCK,
        S_BREACH = PH_BREACH
    } phase_t;

    localparam int DEF_GREEN_TICKS  = 40;
    localparam int DEF_YELLOW_TICKS = 8;
    localparam int DEF_RED_TICKS    = 30;
    localparam int DEF_LOCK_TICKS   = 26;
    localparam int DEF_TW           = 6;

    localparam logic [5:0] LFSR_SEED = 6'h2A;
    localparam logic [5:0] LFSR_TAPS = 6'b110000;

    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/containment_monitor_phase_timer.sv
// Dwell counter: clears on phase change, otherwise counts up and saturates; flags expiry against a limit.
// Counter registered, expiry combinational from the registered count.
module phase_timer
    import containment_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_clear,
    input  logic [TW-1:0] i_limit,
    output logic [TW-1:0] o_dwell,
    output logic          o_expired
);

    logic [TW-1:0] r_dwell;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
        end else if (i_clear) begin
            r_dwell <= '0;
        end else if (r_dwell != {TW{1'b1}}) begin
            r_dwell <= r_dwell + TW'(1);
        end
    end

    assign o_dwell = r_dwell;
    // >= rather than == so a limit that shrinks under the counter still ends the phase
    assign o_expired = (r_dwell >= (i_limit - TW'(1)));

endmodule

// File: rtl/containment_monitor.sv
// Facility light sequencer watching the intruder; escalates alert, locks down, latches breach.
// Optional CONTAINMENT_JITTER_EN adds LFSR jitter (0..7) to the green dwell, latched on GREEN entry.
module containment_monitor
    import containment_pkg::*;
#(
    parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
    parameter int RED_TICKS    = DEF_RED_TICKS,
    parameter int LOCK_TICKS   = DEF_LOCK_TICKS,
    parameter int TW           = DEF_TW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          a1,
    input  logic          a2,
    input  logic          a3,
    input  logic          cheat_in,
    output logic          green,
    output logic          yellow,
    output logic          red,
    output logic [2:0]    phase,
    output logic [TW-1:0] dwell,
    output logic [1:0]    alert_level,
    output logic          lockdown,
    output logic          breach
);

    phase_t        r_phase, w_next;
    logic          r_a1_q, r_a2_q, r_a3_q, r_ch_q;
    logic          r_green, r_yellow, r_red, r_lockdown, r_breach;
    logic [1:0]    r_alert, w_alert_nxt;
    logic          w_a1_rise, w_a2_rise, w_a3_rise, w_ch_rise;
    logic [TW-1:0] w_base_g, w_green_lim, w_limit, w_dwell;
    logic          w_expired;

    assign w_a1_rise = a1 & ~r_a1_q;
    assign w_a2_rise = a2 & ~r_a2_q;
    assign w_a3_rise = a3 & ~r_a3_q;
    assign w_ch_rise = cheat_in & ~r_ch_q;

    always_comb begin
        w_base_g = TW'(GREEN_TICKS >> r_alert);
        if (w_base_g == '0) begin
            w_base_g = TW'(1);
        end
    end

`ifdef CONTAINMENT_JITTER_EN
    logic [5:0] r_lfsr;
    logic [2:0] r_jit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
            r_jit  <= '0;
        end else begin
            if (w_next != S_IDLE && w_next != S_BREACH) begin
                r_lfsr <= lfsr_next(r_lfsr);
            end
            if (w_next == S_GREEN && r_phase != S_GREEN) begin
                r_jit <= r_lfsr[2:0];
            end
        end
    end

    assign w_green_lim = w_base_g + TW'(r_jit);
`else
    assign w_green_lim = w_base_g;
`endif

    always_comb begin
        case (r_phase)
            S_GREEN:  w_limit = w_green_lim;
            S_YELLOW: w_limit = TW'(YELLOW_TICKS);
            S_RED:    w_limit = TW'(RED_TICKS);
            S_LOCK:   w_limit = TW'(LOCK_TICKS);
            default:  w_limit = TW'(1);
        endcase
    end

    phase_timer #(.TW(TW)) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clear   (w_next != r_phase),
        .i_limit   (w_limit),
        .o_dwell   (w_dwell),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_phase;
        case (r_phase)
            S_IDLE: begin
                if (w_a3_rise)   w_next = S_BREACH;
                else if (enable) w_next = S_GREEN;
            end
            S_BREACH: w_next = S_BREACH;
            default: begin
                if (w_a3_rise)                          w_next = S_BREACH;
                else if (!enable)                       w_next = S_IDLE;
                else if (w_ch_rise && r_phase != S_LOCK) w_next = S_LOCK;
                else if (w_expired) begin
                    case (r_phase)
                        S_GREEN:  w_next = S_YELLOW;
                        S_YELLOW: w_next = S_RED;
                        default:  w_next = S_GREEN;
                    endcase
                end
            end
        endcase
    end

    // Any combination of a1/a2/cheat rises in one cycle is a single escalation step
    always_comb begin
        w_alert_nxt = r_alert;
        if (r_phase != S_BREACH) begin
            if (r_phase == S_RED && w_next == S_GREEN && !a1 && !a2) begin
                w_alert_nxt = '0;
            end else if ((w_a1_rise | w_a2_rise | w_ch_rise) && r_alert != 2'd3) begin
                w_alert_nxt = r_alert + 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= S_IDLE;
            r_green    <= 1'b0;
            r_yellow   <= 1'b0;
            r_red      <= 1'b0;
            r_lockdown <= 1'b0;
            r_breach   <= 1'b0;
            r_alert    <= '0;
            r_a1_q     <= 1'b0;
            r_a2_q     <= 1'b0;
            r_a3_q     <= 1'b0;
            r_ch_q     <= 1'b0;
        end else begin
            r_phase    <= w_next;
            r_green    <= (w_next == S_GREEN);
            r_yellow   <= (w_next == S_YELLOW);
            r_red      <= (w_next == S_RED) || (w_next == S_LOCK) || (w_next == S_BREACH);
            r_lockdown <= (w_next == S_LOCK);
            r_breach   <= (w_next == S_BREACH);
            r_alert    <= w_alert_nxt;
            r_a1_q     <= a1;
            r_a2_q     <= a2;
            r_a3_q     <= a3;
            r_ch_q     <= cheat_in;
        end
    end

    assign green       = r_green;
    assign yellow      = r_yellow;
    assign red         = r_red;
    assign phase       = r_phase;
    assign dwell       = w_dwell;
    assign alert_level = r_alert;
    assign lockdown    = r_lockdown;
    assign breach      = r_breach;

endmodule

// File: tb/tb_containment_monitor.sv
// Scoreboard bench for containment_monitor: directed scenarios plus random intruder activity.
// Expected outputs come from a phase/rule reference model; a separate monitor compares each cycle.
module tb_containment_monitor;

    localparam int TW = 6;
    localparam int M_IDLE = 0, M_GREEN = 1, M_YELLOW = 2, M_RED = 3, M_LOCK = 4, M_BREACH = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, cheat_in = 1'b0;
    logic          green, yellow, red, lockdown, breach;
    logic [2:0]    phase;
    logic [TW-1:0] dwell;
    logic [1:0]    alert_level;

    containment_monitor #(
        .GREEN_TICKS(40), .YELLOW_TICKS(8), .RED_TICKS(30), .LOCK_TICKS(26), .TW(TW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .a1(a1), .a2(a2), .a3(a3), .cheat_in(cheat_in),
        .green(green), .yellow(yellow), .red(red), .phase(phase), .dwell(dwell),
        .alert_level(alert_level), .lockdown(lockdown), .breach(breach)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] ph;
        logic       g, y, r;
        logic [5:0] dw;
        logic [1:0] al;
        logic       lk, br;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int m_ph, m_dw, m_al, m_lfsr, m_jit;
    bit p1, p2, p3, pc;

    function automatic exp_t m_out();
        exp_t e;
        e.ph = 3'(m_ph);
        e.g  = (m_ph == M_GREEN);
        e.y  = (m_ph == M_YELLOW);
        e.r  = (m_ph == M_RED) || (m_ph == M_LOCK) || (m_ph == M_BREACH);
        e.dw = 6'(m_dw);
        e.al = 2'(m_al);
        e.lk = (m_ph == M_LOCK);
        e.br = (m_ph == M_BREACH);
        return e;
    endfunction

    task automatic model_reset();
        m_ph = M_IDLE; m_dw = 0; m_al = 0; m_lfsr = 42; m_jit = 0;
        p1 = 0; p2 = 0; p3 = 0; pc = 0;
    endtask

    task automatic model_step(input bit en, input bit i1, input bit i2, input bit i3, input bit ic);
        bit r1, r2, r3, rc;
        int g, lim, nx;
        r1 = i1 && !p1; r2 = i2 && !p2; r3 = i3 && !p3; rc = ic && !pc;
        g = 40 >> m_al;
        if (g < 1) g = 1;
        g = g + m_jit;
        case (m_ph)
            M_GREEN:  lim = g;
            M_YELLOW: lim = 8;
            M_RED:    lim = 30;
            M_LOCK:   lim = 26;
            default:  lim = 1;
        endcase
        nx = m_ph;
        if (m_ph == M_BREACH)            nx = M_BREACH;
        else if (r3)                     nx = M_BREACH;
        else if (m_ph == M_IDLE)         nx = en ? M_GREEN : M_IDLE;
        else if (!en)                    nx = M_IDLE;
        else if (rc && m_ph != M_LOCK)   nx = M_LOCK;
        else if (m_dw >= lim - 1)        nx = (m_ph == M_GREEN) ? M_YELLOW :
                                              (m_ph == M_YELLOW) ? M_RED : M_GREEN;
        if (m_ph != M_BREACH) begin
            if (m_ph == M_RED && nx == M_GREEN && !i1 && !i2) m_al = 0;
            else if ((r1 || r2 || rc) && m_al < 3)            m_al = m_al + 1;
        end
`ifdef CONTAINMENT_JITTER_EN
        if (nx == M_GREEN && m_ph != M_GREEN) m_jit = m_lfsr % 8;
        if (nx != M_IDLE && nx != M_BREACH)
            m_lfsr = ((m_lfsr << 1) & 63) | (((m_lfsr >> 5) ^ (m_lfsr >> 4)) & 1);
`endif
        m_dw = (nx != m_ph) ? 0 : ((m_dw < 63) ? m_dw + 1 : 63);
        m_ph = nx;
        p1 = i1; p2 = i2; p3 = i3; pc = ic;
    endtask

    task automatic cyc(input bit en, input bit i1, input bit i2, input bit i3, input bit ic);
        @(negedge clock);
        reset_n = 1'b1;
        enable = en; a1 = i1; a2 = i2; a3 = i3; cheat_in = ic;
        model_step(en, i1, i2, i3, ic);
        q.push_back(m_out());
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset_n = 1'b0;
            enable = 0; a1 = 0; a2 = 0; a3 = 0; cheat_in = 0;
            model_reset();
            q.push_back(m_out());
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    task automatic run_until(input int ph, input int dw, input int budget, input string nm);
        int n;
        n = 0;
        while (!(m_ph == ph && m_dw == dw) && n < budget) begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (!(m_ph == ph && m_dw == dw)) begin
            errors++;
            $display("FAIL %s: timeout reaching phase %0d dwell %0d (at phase %0d dwell %0d)",
                     nm, ph, dw, m_ph, m_dw);
        end
    endtask

    // monitor: one output word per cycle, compared against the queued expectation
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                exp_t a;
                e = q.pop_front();
                a = {phase, green, yellow, red, dwell, alert_level, lockdown, breach};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got ph=%0d gyr=%b%b%b dw=%0d al=%0d lk=%b br=%b need ph=%0d gyr=%b%b%b dw=%0d al=%0d lk=%b br=%b",
                             $time, a.ph, a.g, a.y, a.r, a.dw, a.al, a.lk, a.br,
                             e.ph, e.g, e.y, e.r, e.dw, e.al, e.lk, e.br);
                end
            end
        end
    end

    initial begin
        int brc;
        bit en_r;
        model_reset();
        do_reset(3);
        settle();
        chk("reset_phase", phase, 0);
        chk("reset_lights", {green, yellow, red}, 0);

        // quiet run: GREEN 40, YELLOW 8, RED 30, back to GREEN at cycle 79
        repeat (40) cyc(1, 0, 0, 0, 0);
        settle();
        chk("green_last_dwell", dwell, 39);
        chk("green_last_phase", phase, M_GREEN);
        cyc(1, 0, 0, 0, 0);
        settle();
        chk("yellow_entry", phase, M_YELLOW);
        repeat (37) cyc(1, 0, 0, 0, 0);
        settle();
        chk("red_last_dwell", dwell, 29);
        cyc(1, 0, 0, 0, 0);
        settle();
        chk("green_again_c79", {phase, dwell}, {3'(M_GREEN), 6'd0});
        chk("alert_quiet", alert_level, 0);

        // escalation via a1 then a2, cleared at RED exit with both low
        cyc(1, 1, 0, 0, 0);
        settle();
        chk("alert_a1", alert_level, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        settle();
        chk("alert_a2", alert_level, 2);
        cyc(1, 0, 0, 0, 0);
        run_until(M_GREEN, 0, 100, "green_after_alert2");
        settle();
        chk("alert_cleared", alert_level, 0);

        // cheat at YELLOW dwell 3 -> LOCK; second cheat inside LOCK doesn't extend
        run_until(M_YELLOW, 3, 100, "yellow_d3");
        cyc(1, 0, 0, 0, 1);
        settle();
        chk("lock_entry", {phase, red, lockdown}, {3'(M_LOCK), 1'b1, 1'b1});
        chk("lock_alert", alert_level, 1);
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        repeat (19) cyc(1, 0, 0, 0, 0);
        settle();
        chk("lock_end_dwell", {phase, dwell}, {3'(M_LOCK), 6'd25});
        cyc(1, 0, 0, 0, 0);
        settle();
        chk("lock_exit", phase, M_GREEN);

        // a3 + cheat together in RED -> BREACH, immune to enable
        run_until(M_RED, 5, 200, "red_d5");
        cyc(1, 0, 0, 1, 1);
        settle();
        chk("breach_entry", {phase, red, breach}, {3'(M_BREACH), 1'b1, 1'b1});
        for (int i = 0; i < 8; i++) cyc(i[0], 0, 0, 0, i[1]);
        settle();
        chk("breach_sticky", breach, 1);
        do_reset(2);
        settle();
        chk("breach_cleared", breach, 0);

        // enable drop mid-GREEN, then fresh 40-cycle GREEN
        cyc(1, 0, 0, 0, 0);
        run_until(M_GREEN, 17, 50, "green_d17");
        cyc(0, 0, 0, 0, 0);
        settle();
        chk("idle_on_disable", {phase, green, yellow, red, dwell}, {3'(M_IDLE), 3'b000, 6'd0});
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (40) cyc(1, 0, 0, 0, 0);
        settle();
        chk("fresh_green_end", dwell, 39);

        // random intruder activity
        brc = 0;
        for (int i = 0; i < 4000; i++) begin
            en_r = ($urandom_range(0, 149) != 0);
            cyc(en_r, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 499) == 0, $urandom_range(0, 49) == 0);
            if (m_ph == M_BREACH) brc++;
            if (brc > 15) begin
                do_reset($urandom_range(1, 3));
                brc = 0;
            end
        end

        repeat (3) @(negedge clock);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
